stream_demultiplexer: RTL and testbench
=======================================

// Module: stream_demultiplexer
//
// PURPOSE
//   Counterpart of the 2:1 multiplexer: one input stream is steered to one of
//   N_OUT output streams, chosen per beat by a control (select) field.
//   Each output has a one-entry holding register and a valid/ready handshake.
//   Sits after a shared producer and fans beats out to independent consumers.
//
// PARAMETERS
//   WIDTH  8  data bits per beat
//   N_OUT  2  number of output channels (2..16)
//   SEL_W  1  select width; must satisfy 2**SEL_W >= N_OUT
//
// PORTS
//   clk        input   1              rising-edge clock, sole clock domain
//   rst        input   1              synchronous, active-high reset
//   in_valid   input   1              input beat present
//   in_ready   output  1              input beat accepted when in_valid && in_ready
//   in_sel     input   SEL_W          destination channel for this beat
//   in_data    input   WIDTH          input payload
//   out_valid  output  N_OUT          bit k: channel k holds a beat
//   out_ready  input   N_OUT          bit k: consumer k takes the beat
//   out_data   output  N_OUT*WIDTH    channel k at [k*WIDTH +: WIDTH]
//   err_sel    output  1              sticky: a beat was dropped because of a bad select
//   beat_cnt   output  16             beats delivered (present only with STREAM_DEMUX_CNT_EN)
//
// BEHAVIOUR
//   - Reset, applied on the clk edge while rst=1:
//     - out_valid=0, out_data=0, err_sel=0, beat_cnt=0.
//     - Pending beats are discarded, including mid-transfer ones.
//     - in_ready is 0 while rst=1.
//   - Per-channel state is EMPTY or FULL.
//     - EMPTY->FULL on accept with in_sel==k.
//     - FULL->EMPTY on out_valid[k]&&out_ready[k].
//     - FULL->FULL, with out_data reloaded, on simultaneous drain and accept for k.
//   - in_ready is combinational: if in_sel<N_OUT, in_ready = !out_valid[in_sel] || out_ready[in_sel].
//   - Latency: a beat accepted at edge t shows out_valid[k]=1 and its data right after edge t.
//     Throughput is 1 beat/cycle per channel while its consumer holds ready=1.
//   - Bad select (in_sel>=N_OUT, or in_sel containing x/z in simulation):
//     - in_ready=1 and the beat is accepted and dropped.
//     - err_sel is set at that edge and holds until rst.
//   - out_data[k] is stable while out_valid[k]&&!out_ready[k]. It holds its last value when EMPTY.
//   - Channel independence: a stalled channel never blocks beats that select a different channel.
//   - No reordering within a channel. Across channels, order follows acceptance order.
//   - out_ready[k] while EMPTY has no effect.
//
// CONFIGURATION
//   - STREAM_DEMUX_CNT_EN defined:
//     - The beat_cnt port exists. It increments by 1 for each edge with any channel draining.
//     - If several channels drain at one edge, it adds the popcount of draining channels.
//     - Wraps 0xFFFF->0. Dropped beats are not counted.
//   - Not defined: the beat_cnt port and its logic are absent. All other behaviour is identical.
//
// TESTING
//   1. Reset, then in_sel=0, in_data=8'hA5, in_valid=1 for 1 cycle, out_ready=2'b01
//      -> out_valid=2'b01 and out_data[7:0]=A5 for 1 cycle; in_ready stays 1.
//   2. Channel 1 stalled (out_ready=2'b00), send sel=1 data 3C then sel=1 data 7E
//      -> second beat held with in_ready=0, out_data[15:8]=3C stable.
//      Raise out_ready[1] -> 3C then 7E delivered in order.
//   3. Channel 1 stalled and FULL, send sel=0 data 11
//      -> in_ready=1, channel 0 receives 11 the next cycle; channel 1 still holds its beat.
//   4. N_OUT=3, SEL_W=2, send in_sel=3 data FF
//      -> in_ready=1, no out_valid rises, err_sel=1 and stays 1; rst clears it.
//   5. Assert rst with both channels FULL
//      -> after the edge out_valid=0, err_sel=0; beats are lost, no delivery after rst falls.
//   6. With STREAM_DEMUX_CNT_EN: stream 65537 beats at full rate to channel 0, out_ready=1
//      -> beat_cnt=1 (wrapped); both channels draining at one edge -> +2.

Source files
------------

// File: rtl/stream_demultiplexer.sv
// One input stream steered per beat to one of N_OUT single-entry output channels.
// Optional delivered-beat counter (beat_cnt port) is built when STREAM_DEMUX_CNT_EN is defined.
module stream_demultiplexer #(
   parameter int WIDTH = 8,
   parameter int N_OUT = 2,
   parameter int SEL_W = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [SEL_W-1:0]       in_sel,
   input  logic [WIDTH-1:0]       in_data,
   output logic [N_OUT-1:0]       out_valid,
   input  logic [N_OUT-1:0]       out_ready,
   output logic [N_OUT*WIDTH-1:0] out_data,
   output logic                   err_sel
`ifdef STREAM_DEMUX_CNT_EN
   ,
   output logic [15:0]            beat_cnt
`endif
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} chan_state_t;

   chan_state_t      state_reg [N_OUT];
   logic [WIDTH-1:0] data_reg  [N_OUT];
   logic [N_OUT-1:0] hit;
   logic [N_OUT-1:0] drain;
   logic             sel_ok;
   logic             accept;

   // An x/z select matches no channel, so it falls into the bad-select path.
   always_comb begin
      hit    = '0;
      sel_ok = 1'b0;
      for (int k = 0; k < N_OUT; k++) begin
         if (in_sel == SEL_W'(k)) begin
            hit[k] = 1'b1;
            sel_ok = 1'b1;
         end
      end
   end

   always_comb begin
      if (rst)
         in_ready = 1'b0;
      else if (sel_ok)
         in_ready = |(hit & (~out_valid | out_ready));
      else
         in_ready = 1'b1;
   end

   assign accept = in_valid && in_ready;
   assign drain  = out_valid & out_ready;

   generate
      for (genvar gi = 0; gi < N_OUT; gi++) begin : g_chan
         always_ff @(posedge clk) begin
            if (rst) begin
               state_reg[gi] <= EMPTY;
               data_reg[gi]  <= '0;
            end else if (accept && hit[gi]) begin
               state_reg[gi] <= FULL;
               data_reg[gi]  <= in_data;
            end else if (drain[gi]) begin
               state_reg[gi] <= EMPTY;
            end
         end

         assign out_valid[gi]                 = (state_reg[gi] == FULL);
         assign out_data[gi*WIDTH +: WIDTH]   = data_reg[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst)
         err_sel <= 1'b0;
      else if (accept && !sel_ok)
         err_sel <= 1'b1;
   end

`ifdef STREAM_DEMUX_CNT_EN
   localparam int CNT_W = $clog2(N_OUT + 1);

   logic [CNT_W-1:0] n_drain;

   always_comb begin
      n_drain = '0;
      for (int k = 0; k < N_OUT; k++)
         n_drain = n_drain + CNT_W'(drain[k]);
   end

   // Free-running 16-bit count; wraps naturally.
   always_ff @(posedge clk) begin
      if (rst)
         beat_cnt <= '0;
      else
         beat_cnt <= beat_cnt + 16'(n_drain);
   end
`endif

endmodule

// File: tb/tb_stream_demultiplexer.sv
// Scoreboard bench for stream_demultiplexer: per-channel expected queues, negedge monitor.
module tb_stream_demultiplexer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        in_valid, in_ready, in_sel;
   logic [7:0]  in_data;
   logic [1:0]  out_valid, out_ready;
   logic [15:0] out_data;
   logic        err_sel;

   logic        in_valid3, in_ready3;
   logic [1:0]  in_sel3;
   logic [7:0]  in_data3;
   logic [2:0]  out_valid3, out_ready3;
   logic [23:0] out_data3;
   logic        err_sel3;
`ifdef STREAM_DEMUX_CNT_EN
   logic [15:0] beat_cnt, beat_cnt3;
`endif

   stream_demultiplexer #(.WIDTH(8), .N_OUT(2), .SEL_W(1)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .err_sel(err_sel)
`ifdef STREAM_DEMUX_CNT_EN
      , .beat_cnt(beat_cnt)
`endif
   );

   stream_demultiplexer #(.WIDTH(8), .N_OUT(3), .SEL_W(2)) dut3 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid3), .in_ready(in_ready3), .in_sel(in_sel3), .in_data(in_data3),
      .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
      .err_sel(err_sel3)
`ifdef STREAM_DEMUX_CNT_EN
      , .beat_cnt(beat_cnt3)
`endif
   );

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] q0[$];
   logic [7:0] q1[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every cycle a channel is valid its data must equal the queue head.
   initial begin
      forever begin
         @(negedge clk);
         if (out_valid[0]) begin
            if (q0.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL ch0_unexpected: got beat %0h expected none", out_data[7:0]);
            end else begin
               check("ch0_data", {24'd0, out_data[7:0]}, {24'd0, q0[0]});
               if (out_ready[0]) void'(q0.pop_front());
            end
         end
         if (out_valid[1]) begin
            if (q1.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL ch1_unexpected: got beat %0h expected none", out_data[15:8]);
            end else begin
               check("ch1_data", {24'd0, out_data[15:8]}, {24'd0, q1[0]});
               if (out_ready[1]) void'(q1.pop_front());
            end
         end
      end
   end

   // Drives one beat for a cycle; returns just after the following rising edge.
   task automatic send(input logic s, input logic [7:0] d, input logic exp_rdy);
      in_valid = 1'b1;
      in_sel   = s;
      in_data  = d;
      @(negedge clk);
      check("send_in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      if (in_ready) begin
         if (s == 1'b0) q0.push_back(d);
         else           q1.push_back(d);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      $display("beat sel=%0d data=%0h in_ready=%0b", s, d, in_ready);
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = '0; out_ready = '0;
      in_valid3 = 1'b0; in_sel3 = '0; in_data3 = '0; out_ready3 = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready",  {31'd0, in_ready},  0);
      check("rst_in_ready3", {31'd0, in_ready3}, 0);
      check("rst_out_valid", {30'd0, out_valid}, 0);
      check("rst_err_sel",   {31'd0, err_sel},   0);
      step(); rst = 1'b0;
      @(negedge clk);
      check("idle_in_ready", {31'd0, in_ready},  1);
      check("idle_out_valid", {30'd0, out_valid}, 0);

      // 1: single beat to channel 0 with consumer ready
      step(); out_ready = 2'b01;
      send(1'b0, 8'hA5, 1'b1);
      @(negedge clk);
      check("t1_out_valid", {30'd0, out_valid}, 32'h1);
      check("t1_in_ready",  {31'd0, in_ready},  1);
      step();
      @(negedge clk);
      check("t1_empty", {30'd0, out_valid}, 0);

      // 2: stalled channel 1, second beat held back, then both delivered in order
      step(); out_ready = 2'b00;
      send(1'b1, 8'h3C, 1'b1);
      in_valid = 1'b1; in_sel = 1'b1; in_data = 8'h7E;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t2_stall_ready", {31'd0, in_ready}, 0);
         check("t2_hold_data", {24'd0, out_data[15:8]}, 32'h3C);
         step();
      end
      out_ready = 2'b10;
      @(negedge clk);
      check("t2_release_ready", {31'd0, in_ready}, 1);
      if (in_ready) q1.push_back(8'h7E);
      step(); in_valid = 1'b0;
      @(negedge clk);
      check("t2_second_valid", {30'd0, out_valid}, 32'h2);
      step();
      @(negedge clk);
      check("t2_q1_drained", q1.size(), 0);
      check("t2_empty", {30'd0, out_valid}, 0);

      // 3: channel 1 stalled and full does not block channel 0
      step(); out_ready = 2'b00;
      send(1'b1, 8'hC3, 1'b1);
      send(1'b0, 8'h11, 1'b1);
      @(negedge clk);
      check("t3_both_valid", {30'd0, out_valid}, 32'h3);
      step(); out_ready = 2'b11;
      step();
      @(negedge clk);
      check("t3_q0_drained", q0.size(), 0);
      check("t3_q1_drained", q1.size(), 0);
      check("t3_empty", {30'd0, out_valid}, 0);

      // 4: N_OUT=3 instance, good select then bad select
      step(); in_valid3 = 1'b1; in_sel3 = 2'd2; in_data3 = 8'h9C;
      @(negedge clk);
      check("t4_good_ready", {31'd0, in_ready3}, 1);
      step(); in_valid3 = 1'b0;
      @(negedge clk);
      check("t4_good_valid", {29'd0, out_valid3}, 32'h4);
      check("t4_good_data", {24'd0, out_data3[23:16]}, 32'h9C);
      $display("beat3 sel=2 data=9c out_valid3=%b", out_valid3);
      step(); in_valid3 = 1'b1; in_sel3 = 2'd3; in_data3 = 8'hFF;
      @(negedge clk);
      check("t4_bad_ready", {31'd0, in_ready3}, 1);
      check("t4_err_before", {31'd0, err_sel3}, 0);
      step(); in_valid3 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t4_err_sticky", {31'd0, err_sel3}, 1);
         check("t4_no_new_valid", {29'd0, out_valid3}, 32'h4);
         step();
      end
      $display("beat3 sel=3 data=ff err_sel3=%0b", err_sel3);

      // 5: reset with both channels full discards the beats
      out_ready = 2'b00;
      send(1'b0, 8'h5A, 1'b1);
      send(1'b1, 8'hB4, 1'b1);
      @(negedge clk);
      check("t5_full", {30'd0, out_valid}, 32'h3);
      step(); rst = 1'b1;
      @(negedge clk);
      check("t5_rst_ready", {31'd0, in_ready}, 0);
      #1;
      q0.delete(); q1.delete();
      step(); rst = 1'b0;
      @(negedge clk);
      check("t5_out_valid", {30'd0, out_valid}, 0);
      check("t5_out_data", {16'd0, out_data}, 0);
      check("t5_err_sel3", {31'd0, err_sel3}, 0);
      check("t5_out_valid3", {29'd0, out_valid3}, 0);
      step(); out_ready = 2'b11;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t5_no_delivery", {30'd0, out_valid}, 0);
      end

`ifdef STREAM_DEMUX_CNT_EN
      // 6: counter wrap after 65537 full-rate beats, then a double drain
      step(); rst = 1'b1;
      step(); rst = 1'b0;
      @(negedge clk);
      check("t6_cnt_reset", {16'd0, beat_cnt}, 0);
      step(); out_ready = 2'b01; in_sel = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 65537; i++) begin
         in_data = i[7:0];
         @(negedge clk);
         if (in_ready) q0.push_back(in_data);
         else begin
            n_cmp++; n_err++;
            $display("FAIL t6_stream_ready: got 0 expected 1 at beat %0d", i);
         end
         step();
      end
      in_valid = 1'b0;
      @(negedge clk);
      step();
      @(negedge clk);
      check("t6_cnt_wrap", {16'd0, beat_cnt}, 1);
      check("t6_q0_drained", q0.size(), 0);
      $display("stream 65537 beats beat_cnt=%0d", beat_cnt);
      step(); out_ready = 2'b00;
      send(1'b0, 8'h01, 1'b1);
      send(1'b1, 8'h02, 1'b1);
      out_ready = 2'b11;
      step();
      @(negedge clk);
      check("t6_cnt_double", {16'd0, beat_cnt}, 3);
`endif

      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
